seg_scan_driver: RTL
====================

# seg_scan_driver

Parametrised, time-multiplexed seven-segment display driver. It replaces the fixed one-hot digit-select decoder with a sequential scanner. The block holds a frame of hex nibbles in a shadow register and cycles an active-low anode select across NUM_DIGITS digits. Each digit slot includes hex-to-segment decoding, per-digit enable, decimal point and a blanking dead-time. It sits between the datapath registers and the board's anode/cathode pins.

## Interface
Parameters:
- NUM_DIGITS, 8, number of digits scanned (1..16)
- SLOT_CYCLES, 100000, clock cycles per digit slot (≥ 2)
- BLANK_CYCLES, 1000, blanked cycles at the start of each slot (1 ≤ BLANK_CYCLES < SLOT_CYCLES)

Ports:
- clk, input, 1, system clock
- rst_n, input, 1, asynchronous active-low reset
- digits_i, input, 4*NUM_DIGITS, hex nibble per digit; digit k = bits [4k+3:4k]
- dp_i, input, NUM_DIGITS, decimal point per digit, active-high
- digit_en_i, input, NUM_DIGITS, per-digit enable; disabled digit shows blank during its slot
- load_i, input, 1, single-cycle request to capture digits_i/dp_i/digit_en_i
- anode_o, output, NUM_DIGITS, active-low digit select, at most one bit low
- seg_o, output, 7, active-low cathodes {g,f,e,d,c,b,a}
- dp_o, output, 1, active-low decimal point
- frame_o, output, 1, one-cycle pulse when the shadow frame is applied at frame start
- busy_o, output, 1, high while a captured load waits for frame start

## Operation
- Datapath registers:
  - pending: holds captured inputs.
  - shadow: holds the frame being displayed.
- Slot counter cnt runs 0..SLOT_CYCLES-1.
- Digit pointer idx runs 0..NUM_DIGITS-1.
- Two-state FSM:
  - BLANK: cnt < BLANK_CYCLES. anode_o all ones, seg_o 7'h7F, dp_o 1.
  - SHOW: cnt ≥ BLANK_CYCLES. anode_o[idx]=0 if shadow_en[idx], else all ones. seg_o = decode(shadow_digit[idx]). dp_o = ~shadow_dp[idx].
- Transitions:
  - BLANK→SHOW when cnt reaches BLANK_CYCLES.
  - SHOW→BLANK when cnt wraps from SLOT_CYCLES-1 to 0. On this wrap idx advances; at NUM_DIGITS-1 it wraps to 0.
- Decode is standard hex, 0-F. For example: 0→7'h40, 1→7'h79, 8→7'h00, F→7'h0E.
- load_i:
  - On the load_i cycle, pending captures the inputs and busy_o rises.
  - A later load_i before frame start overwrites pending; the last capture wins.
- Frame start is the cycle where idx wraps to 0. At frame start with busy_o=1:
  - shadow←pending.
  - frame_o pulses.
  - busy_o clears.
  Without a pending load there is no frame_o pulse and shadow holds.
- load_i in the same cycle as frame start: the new capture goes to pending, busy_o stays 1, and the previous pending is applied. Display never tears mid-frame.
- NUM_DIGITS=1: idx is constant 0, and every slot end is a frame start.

## Timing
- Reset values: anode_o all ones, seg_o 7'h7F, dp_o 1, frame_o 0, busy_o 0, cnt 0, idx 0, FSM BLANK, shadow/pending all zero, shadow_en all zero. The display is dark until the first applied load.
- All outputs come from flops, with one cycle latency from the cnt/idx/FSM state that produces them. No combinational input-to-output path.
- Output timing within a slot:
  - First SHOW output appears BLANK_CYCLES+1 cycles after slot start.
  - Each slot shows for SLOT_CYCLES-BLANK_CYCLES cycles.
  - One full frame = NUM_DIGITS*SLOT_CYCLES cycles.
- Reset mid-slot: outputs go to reset values immediately (async) and scanning restarts from idx 0, BLANK, on the first clk edge after release.
- anode_o changes only in BLANK, so no two anodes are ever low together, including across the slot boundary.

## Configuration
- SEG_LEADING_ZERO_BLANK_EN:
  - Defined: during SHOW, digit k>0 shows blank (anode still driven, seg_o 7'h7F, dp_o 1) if its nibble and all higher-index enabled nibbles are 0 and its dp bit is 0. Digit 0 is never suppressed.
  - Undefined: all enabled digits display their nibble, zeros included.

## Test plan
(NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2 unless noted.)
- Reset, no load → anode_o 4'hF and seg_o 7'h7F for 100 cycles; frame_o never pulses.
- load_i with digits_i=16'h3210, digit_en_i=4'hF, dp_i=0 → at next frame start frame_o pulses once and busy_o drops. Digit 0 then shows seg_o=7'h40 with anode_o=4'hE for 6 cycles after 2 blank cycles. Digits 1..3 show 7'h79, 7'h24, 7'h30 in sequence, then the pattern repeats.
- digit_en_i=4'b1010, dp_i=4'b0010 → slots 0 and 2 keep anode_o=4'hF; slot 1 shows dp_o=0.
- Two load_i mid-frame (16'h1111, then 16'h2222) → only 16'h2222 is displayed after a single frame_o pulse. load_i asserted on the frame-start cycle → busy_o stays 1 and the value applies one frame later.
- rst_n pulsed low during SHOW of digit 2 → anode_o=4'hF asynchronously; after release, digit 0 BLANK restarts, display dark, busy_o 0.
- With SEG_LEADING_ZERO_BLANK_EN, digits_i=16'h0050 → digit 3 blank, digits 1 and 0 show 7'h12 and 7'h40, digit 2 blank. digits_i=16'h0000 → only digit 0 shows 7'h40.

Source files
------------

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment scanner with a double-buffered frame.
// Latency: every output is a flop, one cycle behind the cnt/idx/state that selects it.
// Backpressure: none. load_i is always accepted into pending; pending moves to the
//   displayed frame only at frame start, and a newer load overwrites an older one.
//
// Ports:
//   clk, rst_n      : system clock, asynchronous active-low reset
//   digits_i        : 4*NUM_DIGITS hex nibbles, digit k = bits [4k+3:4k]
//   dp_i            : per-digit decimal point (active-high)
//   digit_en_i      : per-digit enable; a disabled digit stays dark in its slot
//   load_i          : single-cycle capture strobe for digits_i/dp_i/digit_en_i
//   anode_o         : active-low digit select, at most one bit low
//   seg_o           : active-low cathodes {g,f,e,d,c,b,a}
//   dp_o            : active-low decimal point
//   frame_o         : one-cycle pulse when pending is applied at frame start
//   busy_o          : a captured frame is waiting for frame start
//
// Optional feature macro: SEG_LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (k>0, zero nibble, no dp, and every
//   enabled higher digit also zero) are shown blank while their anode stays on.

module seg_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   digit_en_i,
  input  logic                    load_i,
  output logic [NUM_DIGITS-1:0]   anode_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic                    frame_o,
  output logic                    busy_o
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SLOT_CYCLES);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  // Standard active-low hex decode, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Scan state
  state_t                  state_q,  state_d;
  logic [CNT_W-1:0]        cnt_q,    cnt_d;
  logic [IDX_W-1:0]        idx_q,    idx_d;

  // Frame buffers
  logic [4*NUM_DIGITS-1:0] pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q,  pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_en_q,  pend_en_d;
  logic [4*NUM_DIGITS-1:0] shad_dig_q, shad_dig_d;
  logic [NUM_DIGITS-1:0]   shad_dp_q,  shad_dp_d;
  logic [NUM_DIGITS-1:0]   shad_en_q,  shad_en_d;
  logic                    busy_q,     busy_d;

  // Registered outputs
  logic [NUM_DIGITS-1:0]   anode_q, anode_d;
  logic [6:0]              seg_q,   seg_d;
  logic                    dp_q,    dp_d;
  logic                    frame_q, frame_d;

  // Combinational helpers
  logic                    slot_end;
  logic                    frame_start;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_en;
  logic                    cur_sup;

  // Leading-zero suppression mask, derived from the displayed frame only so
  // that it can never change mid-frame.
`ifdef SEG_LEADING_ZERO_BLANK_EN
  always_comb begin
    logic higher_zero;
    suppress    = '0;
    higher_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      suppress[k] = (k != 0) && higher_zero &&
                    (shad_dig_q[4*k +: 4] == 4'h0) && !shad_dp_q[k];
      // Disabled digits are dark anyway and do not stop the zero run.
      if (shad_en_q[k] && (shad_dig_q[4*k +: 4] != 4'h0)) begin
        higher_zero = 1'b0;
      end
    end
  end
`else
  always_comb begin
    suppress = '0;
  end
`endif

  // Select the attributes of the digit currently being scanned.
  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
    cur_en  = 1'b0;
    cur_sup = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_nib = shad_dig_q[4*k +: 4];
        cur_dp  = shad_dp_q[k];
        cur_en  = shad_en_q[k];
        cur_sup = suppress[k];
      end
    end
  end

  always_comb begin
    slot_end    = (cnt_q == CNT_LAST);
    frame_start = slot_end && (idx_q == IDX_LAST);

    // Slot counter and digit pointer
    cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // BLANK covers cnt 0..BLANK_CYCLES-1, SHOW the rest of the slot.
    state_d = state_q;
    case (state_q)
      ST_BLANK: if (cnt_d == CNT_BLANK) state_d = ST_SHOW;
      ST_SHOW:  if (slot_end)           state_d = ST_BLANK;
      default:                          state_d = ST_BLANK;
    endcase

    // Pending capture: the newest load always wins.
    pend_dig_d = pend_dig_q;
    pend_dp_d  = pend_dp_q;
    pend_en_d  = pend_en_q;
    if (load_i) begin
      pend_dig_d = digits_i;
      pend_dp_d  = dp_i;
      pend_en_d  = digit_en_i;
    end

    // Shadow swap only at frame start; a load on that same cycle lands in
    // pending and keeps busy set for the following frame.
    shad_dig_d = shad_dig_q;
    shad_dp_d  = shad_dp_q;
    shad_en_d  = shad_en_q;
    frame_d    = 1'b0;
    busy_d     = busy_q;
    if (frame_start && busy_q) begin
      shad_dig_d = pend_dig_q;
      shad_dp_d  = pend_dp_q;
      shad_en_d  = pend_en_q;
      frame_d    = 1'b1;
      busy_d     = 1'b0;
    end
    if (load_i) begin
      busy_d = 1'b1;
    end

    // Drive pattern for the current state. The anode only ever changes on
    // entering or leaving SHOW, so successive digits are separated by blank.
    anode_d = '1;
    seg_d   = 7'h7F;
    dp_d    = 1'b1;
    if ((state_q == ST_SHOW) && cur_en) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        anode_d[k] = (idx_q != IDX_W'(k));
      end
      if (!cur_sup) begin
        seg_d = hex_to_seg(cur_nib);
        dp_d  = ~cur_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      pend_dig_q <= '0;
      pend_dp_q  <= '0;
      pend_en_q  <= '0;
      shad_dig_q <= '0;
      shad_dp_q  <= '0;
      shad_en_q  <= '0;
      busy_q     <= 1'b0;
      anode_q    <= '1;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
      frame_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      pend_dig_q <= pend_dig_d;
      pend_dp_q  <= pend_dp_d;
      pend_en_q  <= pend_en_d;
      shad_dig_q <= shad_dig_d;
      shad_dp_q  <= shad_dp_d;
      shad_en_q  <= shad_en_d;
      busy_q     <= busy_d;
      anode_q    <= anode_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      frame_q    <= frame_d;
    end
  end

  assign anode_o = anode_q;
  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign frame_o = frame_q;
  assign busy_o  = busy_q;

endmodule
